// File: rtl/cic_decim_ctrl.sv
// CIC decimator control: configuration, integrator clear, comb strobe
// generation, settling discard and a one-entry output sample buffer.
module cic_decim_ctrl #(
  parameter int STAGES     = 4,
  parameter int WIDTH_CTR  = 4,
  parameter int WIDTH_REGS = 1 + STAGES * WIDTH_CTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH_CTR-1:0]  cfg_ratio,
  input  logic [3:0]            cfg_shift,
  input  logic                  enable,
  output logic                  integ_clear,
  output logic                  comb_en,
  input  logic [WIDTH_REGS-1:0] comb_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_data,
  output logic                  overrun,
  output logic                  running
);

  localparam int MAX_SHIFT = WIDTH_REGS - 7;
  localparam int WW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    WARM,
    RUN
  } state_t;

  state_t                 state;
  logic [WIDTH_CTR-1:0]   ratio_q;
  logic [WIDTH_CTR-1:0]   phase;
  logic [WIDTH_CTR-1:0]   phase_nxt;
  logic [3:0]             shift_q;
  logic [3:0]             shift_sat;
  logic [WW-1:0]          warm_cnt;
  logic [WIDTH_REGS-1:0]  shifted;
  logic                   cfg_acc;

  assign cfg_acc = cfg_valid && cfg_ready;

  // Next phase, clamped shift request and bit-selected comb sample.
  always_comb begin
    phase_nxt = '0;
    if (phase != ratio_q)
      phase_nxt = phase + WIDTH_CTR'(1);
    shift_sat = cfg_shift;
    if (int'(cfg_shift) > MAX_SHIFT)
      shift_sat = 4'(MAX_SHIFT);
    shifted = comb_in >> shift_q;
  end

  // Control FSM with registered strobes and output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      integ_clear <= 1'b0;
      comb_en     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      overrun     <= 1'b0;
      running     <= 1'b0;
      phase       <= '0;
      warm_cnt    <= '0;
      ratio_q     <= WIDTH_CTR'(11);
      shift_q     <= 4'(10);
    end else begin
      integ_clear <= 1'b0;
      comb_en     <= 1'b0;
      if (state != IDLE && !enable) begin
        state     <= IDLE;
        cfg_ready <= 1'b1;
        running   <= 1'b0;
        out_valid <= 1'b0;
        phase     <= '0;
        warm_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (cfg_acc) begin
              ratio_q <= cfg_ratio;
              shift_q <= shift_sat;
              overrun <= 1'b0;
            end else if (enable) begin
              state       <= CLEAR;
              cfg_ready   <= 1'b0;
              integ_clear <= 1'b1;
            end
          end
          CLEAR: begin
            state    <= WARM;
            phase    <= '0;
            warm_cnt <= '0;
            comb_en  <= (ratio_q == '0);
          end
          WARM: begin
            phase   <= phase_nxt;
            comb_en <= (phase_nxt == ratio_q);
            if (comb_en) begin
              warm_cnt <= warm_cnt + WW'(1);
              if (warm_cnt == WW'(STAGES - 1)) begin
                state   <= RUN;
                running <= 1'b1;
              end
            end
          end
          RUN: begin
            phase   <= phase_nxt;
            comb_en <= (phase_nxt == ratio_q);
            if (comb_en) begin
              if (!out_valid || out_ready) begin
                out_data  <= shifted[6:0];
                out_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else if (out_valid && out_ready) begin
              out_valid <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Randomized bench for cic_decim_ctrl with a timeline-based
// reference model (strobe schedule plus one-entry buffer).
module tb_cic_decim_ctrl;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_ratio;
  logic [3:0]  cfg_shift;
  logic        enable;
  logic        integ_clear;
  logic        comb_en;
  logic [16:0] comb_in;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic        overrun;
  logic        running;

  int n_chk = 0;
  int n_fail = 0;

  int       m_R;
  int       m_shift;
  bit       m_ovr;
  bit       m_full;
  logic [6:0] m_val;
  int       m_t;
  bit       p_strobe;
  bit       p_rdy;
  logic [16:0] p_in;

  cic_decim_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ratio  (cfg_ratio),
    .cfg_shift  (cfg_shift),
    .enable     (enable),
    .integ_clear(integ_clear),
    .comb_en    (comb_en),
    .comb_in    (comb_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .overrun    (overrun),
    .running    (running)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] sel(input logic [16:0] v);
    logic [16:0] tmp;
    tmp = v >> m_shift;
    return tmp[6:0];
  endfunction

  task automatic model_reset();
    m_R = 12;
    m_shift = 10;
    m_ovr = 0;
    m_full = 0;
  endtask

  task automatic cfg(input int ratio, input int shift, input bit en);
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready);
    end
    n_chk++;
    cfg_valid = 1'b1;
    cfg_ratio = 4'(ratio);
    cfg_shift = 4'(shift);
    enable = en;
    @(negedge clk);
    cfg_valid = 1'b0;
    m_R = ratio + 1;
    m_shift = (shift > 10) ? 10 : shift;
    m_ovr = 0;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_clears_overrun: got %b want 0", overrun);
    end
    n_chk++;
    if (integ_clear !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_priority: clr %b rdy %b want 0 1",
               integ_clear, cfg_ready);
    end
    n_chk++;
  endtask

  task automatic start_run();
    bit seen;
    seen = 0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (integ_clear === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_fail++;
      $display("FAIL start_clear: no integ_clear within 4 cycles");
    end
    n_chk++;
    m_t = 0;
    m_full = 0;
    p_strobe = 0;
    p_rdy = 0;
  endtask

  task automatic run_stream(input int n, input int rdy_pct,
                            input bit fixed, input logic [16:0] fval);
    bit es;
    for (int i = 0; i < n; i++) begin
      if (p_strobe && ((m_t - 1) / m_R) > STAGES) begin
        if (!m_full || p_rdy) begin
          m_full = 1;
          m_val = sel(p_in);
        end else begin
          m_ovr = 1;
        end
      end else if (m_full && p_rdy) begin
        m_full = 0;
      end
      es = (m_t > 0) && (m_t % m_R == 0);
      if (comb_en !== es) begin
        n_fail++;
        $display("FAIL comb_en t=%0d: got %b want %b", m_t, comb_en, es);
      end
      n_chk++;
      if (integ_clear !== (m_t == 0)) begin
        n_fail++;
        $display("FAIL integ_clear t=%0d: got %b", m_t, integ_clear);
      end
      n_chk++;
      if (out_valid !== m_full) begin
        n_fail++;
        $display("FAIL out_valid t=%0d: got %b want %b",
                 m_t, out_valid, m_full);
      end
      n_chk++;
      if (m_full) begin
        if (out_data !== m_val) begin
          n_fail++;
          $display("FAIL out_data t=%0d: got %h want %h",
                   m_t, out_data, m_val);
        end
        n_chk++;
      end
      if (overrun !== m_ovr) begin
        n_fail++;
        $display("FAIL overrun t=%0d: got %b want %b", m_t, overrun, m_ovr);
      end
      n_chk++;
      if (running !== (m_t > STAGES * m_R)) begin
        n_fail++;
        $display("FAIL running t=%0d: got %b", m_t, running);
      end
      n_chk++;
      comb_in = fixed ? fval : 17'($urandom);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ratio = 4'($urandom);
      cfg_shift = 4'($urandom);
      p_strobe = es;
      p_in = comb_in;
      p_rdy = out_ready;
      @(negedge clk);
      m_t++;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic stop_run();
    enable = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    if (cfg_ready !== 1'b1 || out_valid !== 1'b0 ||
        running !== 1'b0 || comb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: rdy %b vld %b run %b ce %b want 1 0 0 0",
               cfg_ready, out_valid, running, comb_en);
    end
    n_chk++;
    if (overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL stop_overrun: got %b want %b", overrun, m_ovr);
    end
    n_chk++;
    m_full = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ratio = '0;
    cfg_shift = '0;
    enable = 1'b0;
    comb_in = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    if (cfg_ready !== 1'b1 || integ_clear !== 1'b0 || comb_en !== 1'b0 ||
        out_valid !== 1'b0 || out_data !== 7'h00 || overrun !== 1'b0 ||
        running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy %b clr %b ce %b vld %b d %h ov %b run %b",
               cfg_ready, integ_clear, comb_en, out_valid, out_data,
               overrun, running);
    end
    n_chk++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default_ratio();
    start_run();
    run_stream(STAGES * 12 + 30, 70, 0, '0);
    stop_run();
  endtask

  task automatic test_ratio_one();
    cfg(0, 0, 0);
    start_run();
    run_stream(30, 100, 1, 17'h0007F);
    stop_run();
  endtask

  task automatic test_shift_clamp();
    cfg(1, 15, 0);
    start_run();
    run_stream(24, 100, 1, 17'h1FC00);
    stop_run();
  endtask

  task automatic test_overrun();
    cfg(3, 2, 0);
    start_run();
    run_stream(21, 100, 0, '0);
    run_stream(12, 0, 0, '0);
    run_stream(10, 60, 0, '0);
    stop_run();
    cfg(3, 2, 0);
  endtask

  task automatic test_back_to_back();
    cfg(0, 3, 1);
    start_run();
    run_stream(60, 50, 0, '0);
    stop_run();
  endtask

  task automatic test_warm_abort();
    cfg(7, 5, 0);
    start_run();
    run_stream(10, 100, 0, '0);
    stop_run();
  endtask

  task automatic test_reset_mid_run();
    cfg(1, 4, 0);
    start_run();
    run_stream(20, 60, 0, '0);
    #2 rst = 1'b1;
    #1;
    if (cfg_ready !== 1'b1 || out_valid !== 1'b0 || running !== 1'b0 ||
        comb_en !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rdy %b vld %b run %b ce %b ov %b",
               cfg_ready, out_valid, running, comb_en, overrun);
    end
    n_chk++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    start_run();
    run_stream(STAGES * 12 + 15, 80, 0, '0);
    stop_run();
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_ratio_one();
    test_shift_clamp();
    test_overrun();
    test_back_to_back();
    test_warm_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of comb stages in the controlled CIC datapath.
REQ-002 SHALL have parameter WIDTH_CTR, default 4, width of the decimation counter; maximum decimation ratio is 2^WIDTH_CTR.
REQ-003 SHALL have parameter WIDTH_REGS, default 1+STAGES*WIDTH_CTR (17), width of the datapath comb output.
REQ-004 SHALL have ports, clock and reset first:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  asynchronous, active-high reset
  cfg_valid  in  1  configuration request
  cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
  cfg_ratio  in  WIDTH_CTR  decimation ratio minus one (R = cfg_ratio+1)
  cfg_shift  in  4  output bit-select LSB position
  enable  in  1  run request; low stops filtering
  integ_clear  out  1  one-cycle clear pulse to datapath integrators and comb buffers
  comb_en  out  1  one-cycle decimation strobe to the comb section
  comb_in  in  WIDTH_REGS  comb-section output sample, valid in the cycle comb_en is high
  out_valid  out  1  output sample available
  out_ready  in  1  consumer accepts sample when out_valid && out_ready
  out_data  out  7  selected output bits
  overrun  out  1  sticky: a decimated sample was dropped
  running  out  1  high in RUN state

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, WARM, RUN.
REQ-006 cfg_ready SHALL be high iff state is IDLE; on acceptance latch cfg_ratio into ratio_q, min(cfg_shift,WIDTH_REGS-7) into shift_q, clear overrun.
REQ-007 IDLE -> CLEAR when enable is high and no configuration is accepted in the same cycle; a same-cycle accept has priority and the transition occurs on the next enable-high cycle.
REQ-008 CLEAR SHALL last exactly one cycle with integ_clear=1, reset the phase counter to 0, then go to WARM.
REQ-009 In WARM and RUN the phase counter SHALL count 0..ratio_q and wrap to 0; comb_en=1 exactly in cycles where counter==ratio_q (every cycle when ratio_q=0).
REQ-010 WARM SHALL discard the first STAGES comb_en samples (comb settling), then enter RUN in the cycle after the STAGES-th strobe.
REQ-011 In RUN, on comb_en, out_data SHALL load comb_in[shift_q+6:shift_q] and out_valid SHALL be high from the next cycle (latency 1).
REQ-012 Output buffer SHALL be one entry; out_valid falls the cycle after a handshake unless a new sample is loaded in the handshake cycle, in which case out_valid stays high with the new data.
REQ-013 comb_en in RUN while out_valid=1 and out_ready=0 SHALL keep the old out_data and set overrun=1; overrun stays set until the next accepted configuration or reset.
REQ-014 enable low in CLEAR, WARM or RUN SHALL go to IDLE next cycle, clearing out_valid, comb_en and the phase counter; a pending sample is discarded.
REQ-015 comb_en and integ_clear SHALL be registered outputs, glitch-free.
REQ-016 cfg inputs SHALL be ignored outside IDLE; ratio_q and shift_q SHALL never change while running.

Reset
REQ-017 rst high SHALL asynchronously force state IDLE, cfg_ready=1, integ_clear=0, comb_en=0, out_valid=0, out_data=0, overrun=0, running=0, phase counter 0, ratio_q=11 (R=12), shift_q=10.
REQ-018 Reset asserted mid-RUN SHALL drop any pending sample; after release the block SHALL need enable low-to-high or held-high to restart via CLEAR.

Verification
REQ-019 Reset then enable=1, no config -> integ_clear one cycle, comb_en period 12 cycles, first out_valid one cycle after the 5th comb_en.
REQ-020 Config ratio=0, shift=0, out_ready=1, comb_in=17'h0007F -> comb_en every cycle, out_data=7'h7F continuously after 4 discarded samples.
REQ-021 Config shift=15 -> shift_q=10; comb_in=17'h1FC00 yields out_data=7'h7F.
REQ-022 RUN, ratio=3, out_ready=0 for 8 cycles -> first sample held, overrun=1 on second strobe; new config clears overrun.
REQ-023 enable dropped mid-WARM and rst pulsed mid-RUN -> IDLE, out_valid=0, cfg_ready=1 next cycle / immediately.
REQ-024 out_ready=1 coincident with comb_en while out_valid=1 -> out_valid stays 1, out_data updates, overrun stays 0.
